// File: rtl/ecc_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SEC/SECDED decoder.
package ecc_pkg;

  typedef enum logic [1:0] {
    ST_CLEAN = 2'b00,
    ST_CORR  = 2'b01,
    ST_DED   = 2'b10,
    ST_INV   = 2'b11
  } status_e;

  // Smallest parity-bit count P with 2^P >= data_w + P + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 0;
    while ((1 << p) < data_w + p + 1) p = p + 1;
    return p;
  endfunction

  // Hamming position (1-based) carrying payload bit idx.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < idx) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) != 0) cnt = cnt + 1;
    end
    return pos;
  endfunction

  // Mask of code bits whose Hamming position has bit j set.
  function automatic logic [63:0] syn_mask(input int n_ham, input int j);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < n_ham; k++) begin
      if ((((k + 1) >> j) & 1) != 0) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for a Hamming codeword.
module hamming_syndrome
  import ecc_pkg::*;
#(
  parameter int N_HAM  = 21,
  parameter int SECDED = 1
) (
  input  logic [N_HAM+SECDED-1:0]      code_i,
  output logic [$clog2(N_HAM+1)-1:0]   syn_o,
  output logic                         par_o
);

  localparam int SW = $clog2(N_HAM + 1);

  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_syn
      localparam logic [63:0] MASK = syn_mask(N_HAM, gi);
      assign syn_o[gi] = ^(code_i[N_HAM-1:0] & MASK[N_HAM-1:0]);
    end
  endgenerate

  assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined Hamming SEC / SECDED decoder with ready/valid handshake
// and saturating corrected / uncorrectable error counters.
module hamming_secded_decoder
  import ecc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SECDED  = 1,
  parameter int CNT_W   = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int N_HAM  = DATA_W + P,
  localparam int N      = N_HAM + SECDED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_status,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  localparam logic [P-1:0] N_HAM_S = P'(N_HAM);

  logic             adv;
  logic             out_xfer;
  logic [P-1:0]     syn;
  logic             par;

  logic             s1_valid_q;
  logic [N_HAM-1:0] s1_code_q;
  logic [P-1:0]     s1_syn_q;
  logic             s1_par_q;

  logic             out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  status_e          out_status_q;

  logic [DATA_W-1:0] data_d;
  status_e          status_d;
  logic             flip_en;

  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_uncorr_q, cnt_uncorr_d;

  logic             unused_code;

  hamming_syndrome #(
    .N_HAM  (N_HAM),
    .SECDED (SECDED)
  ) u_syndrome (
    .code_i (in_code),
    .syn_o  (syn),
    .par_o  (par)
  );

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    status_d = ST_CLEAN;
    flip_en  = 1'b0;
    if (SECDED != 0) begin
      if (s1_syn_q == '0) begin
        status_d = s1_par_q ? ST_CORR : ST_CLEAN;
      end else if (!s1_par_q) begin
        status_d = ST_DED;
      end else if (s1_syn_q <= N_HAM_S) begin
        status_d = ST_CORR;
        flip_en  = 1'b1;
      end else begin
        status_d = ST_INV;
      end
    end else begin
      if (s1_syn_q == '0) begin
        status_d = ST_CLEAN;
      end else if (s1_syn_q <= N_HAM_S) begin
        status_d = ST_CORR;
        flip_en  = 1'b1;
      end else begin
        status_d = ST_INV;
      end
    end
  end

  // Only payload positions are ever corrected; a syndrome pointing at a
  // parity position still reports ST_CORR with the payload untouched.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam int POS = data_pos(gi);
      assign data_d[gi] = s1_code_q[POS-1] ^ (flip_en && (s1_syn_q == P'(POS)));
    end
  endgenerate

  assign unused_code = ^s1_code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= ST_CLEAN;
    end else if (adv) begin
      s1_valid_q   <= in_valid;
      s1_code_q    <= in_code[N_HAM-1:0];
      s1_syn_q     <= syn;
      s1_par_q     <= par;
      out_valid_q  <= s1_valid_q;
      out_data_q   <= data_d;
      out_status_q <= status_d;
    end
  end

  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end else if (out_xfer) begin
      if ((out_status_q == ST_CORR) && (cnt_corr_q != '1))
        cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (((out_status_q == ST_DED) || (out_status_q == ST_INV)) && (cnt_uncorr_q != '1))
        cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_status = out_status_q;
  assign cnt_corr   = cnt_corr_q;
  assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench: directed vector table, counter corner cases, and a
// randomized stall/stream run scored against a behavioural decode model.
module tb_hamming_secded_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: DATA_W=16, SECDED=1, CNT_W=16
  logic [21:0] in_code_a;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, cnt_clr_a;
  logic [15:0] out_data_a;
  logic [1:0]  out_status_a;
  logic [15:0] cnt_corr_a, cnt_uncorr_a;

  // DUT B: DATA_W=16, SECDED=0, CNT_W=4
  logic [20:0] in_code_b;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, cnt_clr_b;
  logic [15:0] out_data_b;
  logic [1:0]  out_status_b;
  logic [3:0]  cnt_corr_b, cnt_uncorr_b;

  hamming_secded_decoder #(.DATA_W(16), .SECDED(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_code(in_code_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_status(out_status_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .cnt_clr(cnt_clr_a), .cnt_corr(cnt_corr_a), .cnt_uncorr(cnt_uncorr_a)
  );

  hamming_secded_decoder #(.DATA_W(16), .SECDED(0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_code(in_code_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_status(out_status_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .cnt_clr(cnt_clr_b), .cnt_corr(cnt_corr_b), .cnt_uncorr(cnt_uncorr_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decode by the textbook rules: syndrome = XOR of indices of set positions.
  function automatic logic [17:0] model(input logic [21:0] code, input bit secded);
    int s;
    bit p;
    int idx;
    logic [21:0] c;
    logic [1:0] st;
    logic [15:0] d;
    s = 0;
    c = code;
    for (int k = 0; k < 21; k++) if (code[k]) s = s ^ (k + 1);
    p = ^code;
    st = 2'b00;
    if (secded) begin
      if (s == 0) st = p ? 2'b01 : 2'b00;
      else if (!p) st = 2'b10;
      else if (s <= 21) begin st = 2'b01; c[s-1] = ~c[s-1]; end
      else st = 2'b11;
    end else begin
      if (s == 0) st = 2'b00;
      else if (s <= 21) begin st = 2'b01; c[s-1] = ~c[s-1]; end
      else st = 2'b11;
    end
    d = '0;
    idx = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[idx] = c[pos-1];
        idx++;
      end
    end
    return {st, d};
  endfunction

  function automatic logic [21:0] encode(input logic [15:0] d);
    logic [21:0] c;
    int idx;
    int s;
    c = '0;
    idx = 0;
    s = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[idx];
        idx++;
      end
    end
    for (int k = 0; k < 21; k++) if (c[k]) s = s ^ (k + 1);
    for (int j = 0; j < 5; j++) if (((s >> j) & 1) != 0) c[(1 << j) - 1] = 1'b1;
    c[21] = ^c[20:0];
    return c;
  endfunction

  function automatic logic [21:0] rand_code();
    logic [21:0] c;
    int nflip;
    if ($urandom_range(0, 1) == 1) return 22'($urandom);
    c = encode(16'($urandom));
    nflip = $urandom_range(0, 2);
    for (int i = 0; i < nflip; i++) begin
      int b;
      b = $urandom_range(0, 21);
      c[b] = ~c[b];
    end
    return c;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  logic [17:0] exp_q[$];
  int  m_corr_a = 0, m_uncorr_a = 0;
  int  m_corr_b = 0, m_uncorr_b = 0;
  bit  hold_pending = 0;
  bit  last_accept = 0;

  // One cycle on DUT A: drive, then score whatever transfers at the next edge.
  task automatic step(input logic iv, input logic [21:0] code, input logic ordy, input logic clr);
    logic [17:0] e;
    @(negedge clk);
    in_valid_a  = iv;
    in_code_a   = code;
    out_ready_a = ordy;
    cnt_clr_a   = clr;
    #1;
    check("cnt_corr", cnt_corr_a, m_corr_a);
    check("cnt_uncorr", cnt_uncorr_a, m_uncorr_a);
    if (hold_pending) check("stall_valid", out_valid_a, 1);
    last_accept = iv && in_ready_a;
    if (out_valid_a) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid_a, 0);
      end else begin
        check("out_head", {out_status_a, out_data_a}, exp_q[0]);
        if (ordy) begin
          e = exp_q.pop_front();
          if (e[17:16] == 2'b01) m_corr_a = sat(m_corr_a, 65535);
          else if (e[17]) m_uncorr_a = sat(m_uncorr_a, 65535);
        end
      end
    end
    if (clr) begin
      m_corr_a = 0;
      m_uncorr_a = 0;
    end
    hold_pending = out_valid_a && !ordy;
    if (last_accept) exp_q.push_back(model(code, 1'b1));
  endtask

  typedef struct {
    bit          sel;
    logic [21:0] code;
    logic [15:0] exp_data;
    logic [1:0]  exp_st;
    string       name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic ov, ir;
    logic [15:0] od;
    logic [1:0] os;
    logic [21:0] codes8[8];
    int idx, cyc;

    tbl[0] = '{0, 22'h000000, 16'h0000, 2'b00, "zero"};
    tbl[1] = '{0, 22'h000010, 16'h0000, 2'b01, "pos5"};
    tbl[2] = '{0, 22'h000011, 16'h0002, 2'b10, "pos1_5_ded"};
    tbl[3] = '{0, 22'h200000, 16'h0000, 2'b01, "ovp_only"};
    tbl[4] = '{0, 22'h200007, 16'h0001, 2'b00, "d1_clean"};
    tbl[5] = '{0, 22'h200003, 16'h0001, 2'b01, "d1_pos3"};
    tbl[6] = '{0, 22'h0080C0, 16'h0008, 2'b11, "inv_syn31"};
    tbl[7] = '{1, 22'h00C000, 16'h0400, 2'b11, "sec0_inv"};
    tbl[8] = '{1, 22'h000010, 16'h0000, 2'b01, "sec0_pos5"};
    tbl[9] = '{1, 22'h000000, 16'h0000, 2'b00, "sec0_zero"};

    rst = 1'b1;
    in_code_a = '0; in_valid_a = 0; out_ready_a = 0; cnt_clr_a = 0;
    in_code_b = '0; in_valid_b = 0; out_ready_b = 0; cnt_clr_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_out_status", out_status_a, 0);
    check("rst_cnt_corr", cnt_corr_a, 0);
    check("rst_cnt_uncorr", cnt_uncorr_a, 0);
    check("rst_b_out_valid", out_valid_b, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("in_ready_after_rst", in_ready_a, 1);
    $display("reset checks done");

    // Directed vectors, one transaction at a time with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tbl[i].sel) begin
        in_code_b = tbl[i].code[20:0]; in_valid_b = 1; out_ready_b = 1;
      end else begin
        in_code_a = tbl[i].code; in_valid_a = 1; out_ready_a = 1;
      end
      #1;
      ir = tbl[i].sel ? in_ready_b : in_ready_a;
      check({tbl[i].name, "_in_ready"}, ir, 1);
      @(negedge clk);
      in_valid_a = 0; in_valid_b = 0;
      #1;
      ov = tbl[i].sel ? out_valid_b : out_valid_a;
      check({tbl[i].name, "_early_valid"}, ov, 0);
      @(negedge clk);
      #1;
      ov = tbl[i].sel ? out_valid_b : out_valid_a;
      od = tbl[i].sel ? out_data_b : out_data_a;
      os = tbl[i].sel ? out_status_b : out_status_a;
      check({tbl[i].name, "_valid"}, ov, 1);
      check({tbl[i].name, "_data"}, od, tbl[i].exp_data);
      check({tbl[i].name, "_status"}, os, tbl[i].exp_st);
      if (tbl[i].sel) begin
        if (tbl[i].exp_st == 2'b01) m_corr_b = sat(m_corr_b, 15);
        else if (tbl[i].exp_st[1]) m_uncorr_b = sat(m_uncorr_b, 15);
      end else begin
        if (tbl[i].exp_st == 2'b01) m_corr_a = sat(m_corr_a, 65535);
        else if (tbl[i].exp_st[1]) m_uncorr_a = sat(m_uncorr_a, 65535);
      end
      @(negedge clk);
      #1;
      check({tbl[i].name, "_cnt_corr_a"}, cnt_corr_a, m_corr_a);
      check({tbl[i].name, "_cnt_uncorr_a"}, cnt_uncorr_a, m_uncorr_a);
      check({tbl[i].name, "_cnt_corr_b"}, cnt_corr_b, m_corr_b);
      check({tbl[i].name, "_cnt_uncorr_b"}, cnt_uncorr_b, m_uncorr_b);
      $display("vec %0d %s code=%06h data=%04h status=%0d", i, tbl[i].name, tbl[i].code, od, os);
    end

    // Saturate the 4-bit corrected counter on DUT B.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_code_b = 21'h000010; in_valid_b = 1; out_ready_b = 1;
      m_corr_b = sat(m_corr_b, 15);
    end
    @(negedge clk);
    in_valid_b = 0;
    repeat (3) @(negedge clk);
    #1;
    check("sat_cnt_corr", cnt_corr_b, m_corr_b);
    check("sat_cnt_corr_allones", cnt_corr_b, 4'hF);
    $display("saturation cnt_corr_b=%0h", cnt_corr_b);

    // Clear coinciding with a status-01 output transfer.
    @(negedge clk);
    in_code_b = 21'h000010; in_valid_b = 1;
    @(negedge clk);
    in_valid_b = 0;
    @(negedge clk);
    #1;
    check("clr_out_valid", out_valid_b, 1);
    check("clr_out_status", out_status_b, 2'b01);
    cnt_clr_b = 1;
    @(negedge clk);
    cnt_clr_b = 0;
    #1;
    check("clr_cnt_corr", cnt_corr_b, 0);
    check("clr_cnt_uncorr", cnt_uncorr_b, 0);
    $display("clear with same-cycle increment cnt_corr_b=%0h", cnt_corr_b);

    // Eight codewords under the out_ready pattern 1,0,0,...
    for (int i = 0; i < 8; i++) codes8[i] = rand_code();
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      step(1'b1, codes8[idx], (cyc % 3) == 0, 1'b0);
      if (last_accept) begin
        $display("stream8 accept %0d code=%06h", idx, codes8[idx]);
        idx++;
      end
      cyc++;
    end
    check("stream8_all_accepted", idx, 8);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step(1'b0, 22'h0, (cyc % 3) == 0, 1'b0);
      cyc++;
    end
    check("stream8_drained", exp_q.size(), 0);

    // Randomized stream with random stalls, bubbles and occasional clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_code(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step(1'b0, 22'h0, 1'b1, 1'b0);
      cyc++;
    end
    check("random_drained", exp_q.size(), 0);
    $display("random stream done checks=%0d", checks);

    // Reset with the pipeline full and stalled.
    step(1'b1, rand_code(), 1'b1, 1'b0);
    step(1'b1, rand_code(), 1'b1, 1'b0);
    step(1'b1, rand_code(), 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid_a = 0;
    #1;
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_out_data", out_data_a, 0);
    check("midrst_out_status", out_status_a, 0);
    check("midrst_cnt_corr", cnt_corr_a, 0);
    check("midrst_cnt_uncorr", cnt_uncorr_a, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_corr_a = 0;
    m_uncorr_a = 0;
    hold_pending = 0;
    #1;
    check("midrst_in_ready", in_ready_a, 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 22'h0, 1'b1, 1'b0);
      check("post_rst_no_out", out_valid_a, 0);
    end
    $display("mid-stream reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
